// File: rtl/apb_master_mc_pkg.sv
// Purpose: shared types and helpers for the multi-slave APB4 master and its decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_master_mc_pkg;

    // Master FSM states; DERR is the one-cycle slot for an out-of-range slave index.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DERR   = 2'd3
    } apb_state_e;

    // Byte-strobe width for a given data width.
    function automatic int apb_strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/apb_master_mc_if.sv
// Purpose: request/response port plus the N-slave APB bus of the master, as one bundle.
// Latency: n/a (wires only).
// Backpressure: req_ready from the master; the response side has none.
interface apb_master_mc_if
    import apb_master_mc_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 2
);
    localparam int STRB_W = apb_strb_w(DATA_W);

    logic                        req_valid;
    logic                        req_ready;
    logic                        req_write;
    logic [ADDR_W-1:0]           req_addr;
    logic [DATA_W-1:0]           req_wdata;
    logic [STRB_W-1:0]           req_strb;
    logic                        rsp_valid;
    logic [DATA_W-1:0]           rsp_rdata;
    logic                        rsp_err;
    logic                        rsp_tmo;
    logic [NUM_SLV-1:0]          psel;
    logic                        penable;
    logic                        pwrite;
    logic [ADDR_W-1:0]           paddr;
    logic [DATA_W-1:0]           pwdata;
    logic [STRB_W-1:0]           pstrb;
    logic [NUM_SLV*DATA_W-1:0]   prdata;
    logic [NUM_SLV-1:0]          pready;
    logic [NUM_SLV-1:0]          pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb,
        input  prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
        output psel, penable, pwrite, paddr, pwdata, pstrb
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb,
        output prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
        input  psel, penable, pwrite, paddr, pwdata, pstrb
    );

endinterface

// File: rtl/apb_master_mc_slv_decode.sv
// Purpose: slave index -> one-hot PSEL vector plus out-of-range flag.
// Latency: combinational.
// Backpressure: none.
module apb_slv_decode
    import apb_master_mc_pkg::*;
#(
    parameter int NUM_SLV = 2,
    parameter int SEL_W   = 4
) (
    input  logic [SEL_W-1:0]   idx_i,
    output logic [NUM_SLV-1:0] sel_o,
    output logic               oor_o
);

    // One-hot select for in-range indices; an out-of-range index selects nobody.
    always_comb begin
        sel_o = '0;
        oor_o = (int'(idx_i) >= NUM_SLV);
        for (int i = 0; i < NUM_SLV; i++) begin
            sel_o[i] = (int'(idx_i) == i);
        end
    end

endmodule

// File: rtl/apb_master_mc.sv
// Purpose: APB4 master for NUM_SLV slaves with address decode, PSTRB, PSLVERR and access timeout.
// Latency: accept -> SETUP -> ACCESS (>=1) -> registered rsp pulse; decode error answers 2 cycles after accept.
// Backpressure: req_ready only in IDLE or on the completing ACCESS cycle; rsp cannot be stalled.
module apb_master_mc
    import apb_master_mc_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 2,
    parameter int SEL_LSB = 28,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 pclk,
    input  logic                 prst,
    apb_master_mc_if.master      bus
);
    localparam int STRB_W   = apb_strb_w(DATA_W);
    localparam int CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    apb_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_SLV-1:0]  psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [STRB_W-1:0]   pstrb_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic                rsp_tmo_q;

    logic [SEL_W-1:0]    req_idx;
    logic [NUM_SLV-1:0]  dec_sel;
    logic                dec_oor;
    logic [DATA_W-1:0]   prdata_sel;
    logic                pready_sel;
    logic                pslverr_sel;
    logic                tmo_hit;
    logic                done;
    logic                accept;

    assign req_idx = bus.req_addr[SEL_LSB +: SEL_W];

    apb_slv_decode #(
        .NUM_SLV (NUM_SLV),
        .SEL_W   (SEL_W)
    ) u_decode (
        .idx_i   (req_idx),
        .sel_o   (dec_sel),
        .oor_o   (dec_oor)
    );

    // Pick the active slave's return signals; psel_q is one-hot whenever it matters.
    always_comb begin
        prdata_sel  = '0;
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (psel_q[i]) begin
                prdata_sel  = prdata_sel | bus.prdata[i*DATA_W +: DATA_W];
                pready_sel  = pready_sel | bus.pready[i];
                pslverr_sel = pslverr_sel | bus.pslverr[i];
            end
        end
    end

    // A slave answering on the last allowed cycle beats the timeout.
    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TMO_LAST)) && !pready_sel;
    assign done    = (state_q == ST_ACCESS) && (pready_sel || tmo_hit);

    assign bus.req_ready = (state_q == ST_IDLE) || done;
    assign accept        = bus.req_valid && bus.req_ready;

    // Transfer FSM with registered APB and response outputs; a new accept overrides the return to IDLE.
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            case (state_q)
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (done) begin
                        rsp_valid_q <= 1'b1;
                        if (pready_sel) begin
                            rsp_rdata_q <= pwrite_q ? '0 : prdata_sel;
                            rsp_err_q   <= pslverr_sel;
                        end else begin
                            rsp_err_q   <= 1'b1;
                            rsp_tmo_q   <= 1'b1;
                        end
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DERR: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                end
            endcase
            if (accept) begin
                paddr_q   <= bus.req_addr;
                pwrite_q  <= bus.req_write;
                pwdata_q  <= bus.req_wdata;
                pstrb_q   <= bus.req_write ? bus.req_strb : '0;
                penable_q <= 1'b0;
                if (dec_oor) begin
                    psel_q  <= '0;
                    state_q <= ST_DERR;
                end else begin
                    psel_q  <= dec_sel;
                    state_q <= ST_SETUP;
                end
            end
        end
    end

    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.pstrb     = pstrb_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_tmo   = rsp_tmo_q;

endmodule

// File: tb/tb_apb_master_mc.sv
// Purpose: directed self-checking bench for apb_master_mc (2 slaves, TIMEOUT=4).
// Latency: checks cycle-exact SETUP/ACCESS/response timing.
// Backpressure: exercises req_ready in IDLE, SETUP, waiting ACCESS and completing ACCESS.
module tb_apb_master_mc;
    import apb_master_mc_pkg::*;

    logic pclk;
    logic prst;
    int   n_vec;
    int   n_miss;

    apb_master_mc_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(2)) bus ();

    apb_master_mc #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .NUM_SLV (2),
        .SEL_LSB (28),
        .SEL_W   (4),
        .TIMEOUT (4)
    ) dut (
        .pclk (pclk),
        .prst (prst),
        .bus  (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic put_req(input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_strb  = strb;
    endtask

    task automatic drop_req();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        prst          = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_strb  = '0;
        bus.prdata    = '0;
        bus.pready    = '0;
        bus.pslverr   = '0;

        // Reset state
        #12;
        chk("rst_psel",    bus.psel,      0);
        chk("rst_penable", bus.penable,   0);
        chk("rst_paddr",   bus.paddr,     0);
        chk("rst_rspv",    bus.rsp_valid, 0);
        chk("rst_ready",   bus.req_ready, 1);
        tick();
        prst = 1'b1;
        tick();

        // 1: write to slave1, ready at once
        bus.prdata = {32'h1111_2222, 32'h3333_4444};
        bus.pready = 2'b10;
        put_req(1'b1, 32'h1000_0004, 32'hA5A5_0001, 4'hF);
        chk("t1_ready_idle", bus.req_ready, 1);
        tick();
        drop_req();
        chk("t1_setup_psel", bus.psel,    2'b10);
        chk("t1_setup_pen",  bus.penable, 0);
        chk("t1_paddr",      bus.paddr,   32'h1000_0004);
        chk("t1_pwrite",     bus.pwrite,  1);
        chk("t1_pwdata",     bus.pwdata,  32'hA5A5_0001);
        chk("t1_pstrb",      bus.pstrb,   4'hF);
        tick();
        chk("t1_acc_psel",   bus.psel,      2'b10);
        chk("t1_acc_pen",    bus.penable,   1);
        chk("t1_acc_rspv",   bus.rsp_valid, 0);
        tick();
        chk("t1_rspv",       bus.rsp_valid, 1);
        chk("t1_rsp_err",    bus.rsp_err,   0);
        chk("t1_rsp_rdata",  bus.rsp_rdata, 0);
        chk("t1_idle_psel",  bus.psel,      0);
        chk("t1_idle_pen",   bus.penable,   0);
        chk("t1_hold_paddr", bus.paddr,     32'h1000_0004);
        tick();
        chk("t1_rspv_pulse", bus.rsp_valid, 0);

        // 2: read slave0, 3 wait states; unselected slave1 ready+error ignored
        bus.pready  = 2'b10;
        bus.pslverr = 2'b10;
        bus.prdata  = {32'h1111_2222, 32'hDEAD_BEEF};
        put_req(1'b0, 32'h0000_0010, 32'h0, 4'hF);
        tick();
        drop_req();
        chk("t2_setup_psel", bus.psel,   2'b01);
        chk("t2_pstrb_rd",   bus.pstrb,  0);
        chk("t2_pwrite",     bus.pwrite, 0);
        tick();
        for (int c = 0; c < 3; c++) begin
            chk("t2_wait_pen",   bus.penable,   1);
            chk("t2_wait_rspv",  bus.rsp_valid, 0);
            chk("t2_wait_ready", bus.req_ready, 0);
            tick();
        end
        bus.pready = 2'b11;
        chk("t2_last_pen",   bus.penable,   1);
        chk("t2_done_ready", bus.req_ready, 1);
        tick();
        bus.pready  = 2'b00;
        bus.pslverr = 2'b00;
        chk("t2_rspv",       bus.rsp_valid, 1);
        chk("t2_rdata",      bus.rsp_rdata, 32'hDEAD_BEEF);
        chk("t2_err",        bus.rsp_err,   0);
        chk("t2_tmo",        bus.rsp_tmo,   0);
        tick();

        // 3: back-to-back write slave0 then read slave1
        bus.pready = 2'b11;
        bus.prdata = {32'hCAFE_0001, 32'h5555_6666};
        put_req(1'b1, 32'h0000_0020, 32'h0000_0011, 4'h3);
        tick();
        put_req(1'b0, 32'h1000_0030, 32'h0, 4'hF);
        chk("t3_setup_ready", bus.req_ready, 0);
        chk("t3_a_psel",      bus.psel,      2'b01);
        tick();
        chk("t3_a_pen",       bus.penable,   1);
        chk("t3_a_ready",     bus.req_ready, 1);
        tick();
        drop_req();
        chk("t3_a_rspv",      bus.rsp_valid, 1);
        chk("t3_a_rdata",     bus.rsp_rdata, 0);
        chk("t3_b_psel",      bus.psel,      2'b10);
        chk("t3_b_pen",       bus.penable,   0);
        chk("t3_b_paddr",     bus.paddr,     32'h1000_0030);
        tick();
        chk("t3_b_accpen",    bus.penable,   1);
        chk("t3_b_norsp",     bus.rsp_valid, 0);
        tick();
        chk("t3_b_rspv",      bus.rsp_valid, 1);
        chk("t3_b_rdata",     bus.rsp_rdata, 32'hCAFE_0001);
        chk("t3_b_idle",      bus.psel,      0);
        tick();

        // 4: decode error
        put_req(1'b0, 32'hF000_0000, 32'h0, 4'h0);
        tick();
        drop_req();
        chk("t4_derr_psel",  bus.psel,      0);
        chk("t4_derr_pen",   bus.penable,   0);
        chk("t4_derr_rspv",  bus.rsp_valid, 0);
        chk("t4_derr_ready", bus.req_ready, 0);
        tick();
        chk("t4_rspv",       bus.rsp_valid, 1);
        chk("t4_err",        bus.rsp_err,   1);
        chk("t4_rdata",      bus.rsp_rdata, 0);
        chk("t4_tmo",        bus.rsp_tmo,   0);
        chk("t4_psel",       bus.psel,      0);
        tick();
        chk("t4_ready_idle", bus.req_ready, 1);

        // 5: timeout with slave1 never ready
        bus.pready = 2'b00;
        put_req(1'b0, 32'h1000_0000, 32'h0, 4'h0);
        tick();
        drop_req();
        tick();
        for (int c = 0; c < 4; c++) begin
            chk("t5_acc_pen",  bus.penable,   1);
            chk("t5_acc_rspv", bus.rsp_valid, 0);
            chk("t5_acc_ready", bus.req_ready, (c == 3) ? 64'd1 : 64'd0);
            tick();
        end
        chk("t5_rspv",  bus.rsp_valid, 1);
        chk("t5_err",   bus.rsp_err,   1);
        chk("t5_tmo",   bus.rsp_tmo,   1);
        chk("t5_rdata", bus.rsp_rdata, 0);
        chk("t5_psel",  bus.psel,      0);
        chk("t5_pen",   bus.penable,   0);
        tick();

        // 6a: PSLVERR on a write to slave0
        bus.pready  = 2'b01;
        bus.pslverr = 2'b01;
        put_req(1'b1, 32'h0000_0008, 32'h0000_0077, 4'h1);
        tick();
        drop_req();
        tick();
        tick();
        chk("t6_rspv", bus.rsp_valid, 1);
        chk("t6_err",  bus.rsp_err,   1);
        chk("t6_tmo",  bus.rsp_tmo,   0);
        bus.pslverr = 2'b00;
        bus.pready  = 2'b00;
        tick();

        // 6b: reset in the middle of ACCESS
        put_req(1'b0, 32'h1000_0040, 32'h0, 4'h0);
        tick();
        drop_req();
        tick();
        chk("t6_acc_pen", bus.penable, 1);
        prst = 1'b0;
        #1;
        chk("t6_rst_psel",  bus.psel,      0);
        chk("t6_rst_pen",   bus.penable,   0);
        chk("t6_rst_paddr", bus.paddr,     0);
        chk("t6_rst_rspv",  bus.rsp_valid, 0);
        bus.pready = 2'b11;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("t6_rst_norsp", bus.rsp_valid, 0);
        end
        prst = 1'b1;
        tick();
        chk("t6_after_rspv",  bus.rsp_valid, 0);
        chk("t6_after_ready", bus.req_ready, 1);
        chk("t6_after_psel",  bus.psel,      0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
